// File: rtl/cvxif_offload_requester.sv
// Core-side CV-X-IF requester: one offload command at a time through issue/register, commit, result, response.
// Optional result watchdog is enabled by defining CVXIF_REQ_TIMEOUT_EN.
module cvxif_offload_requester #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned IdWidth = 4
`ifdef CVXIF_REQ_TIMEOUT_EN
    ,
    parameter int unsigned TimeoutCycles = 1024
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    // Every channel: a transfer happens on a rising edge with valid & ready high; the
    // sender holds valid and keeps its payload stable until that transfer.
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [31:0]        cmd_instr_i,
    input  logic [XLEN-1:0]    cmd_rs1_i,
    input  logic [XLEN-1:0]    cmd_rs2_i,
    input  logic [IdWidth-1:0] cmd_id_i,
    output logic               issue_valid_o,
    input  logic               issue_ready_i,
    output logic [31:0]        issue_instr_o,
    output logic [IdWidth-1:0] issue_id_o,
    input  logic               issue_accept_i,
    input  logic               issue_writeback_i,
    output logic               register_valid_o,
    input  logic               register_ready_i,
    output logic [XLEN-1:0]    register_rs1_o,
    output logic [XLEN-1:0]    register_rs2_o,
    output logic [IdWidth-1:0] register_id_o,
    output logic               commit_valid_o,
    output logic [IdWidth-1:0] commit_id_o,
    output logic               commit_kill_o,
    input  logic               result_valid_i,
    output logic               result_ready_o,
    input  logic [IdWidth-1:0] result_id_i,
    input  logic [XLEN-1:0]    result_data_i,
    input  logic [4:0]         result_rd_i,
    input  logic               result_we_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [XLEN-1:0]    rsp_data_o,
    output logic [4:0]         rsp_rd_o,
    output logic               rsp_we_o,
    output logic [1:0]         rsp_status_o,
    output logic [2:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_COMMIT,
        S_WAIT_RES,
        S_RSP
    } state_e;

    localparam logic [1:0] STATUS_OK       = 2'd0;
    localparam logic [1:0] STATUS_REJECTED = 2'd1;
`ifdef CVXIF_REQ_TIMEOUT_EN
    localparam logic [1:0] STATUS_TIMEOUT  = 2'd2;
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
`endif

    state_e state;
    logic   issue_done;
    logic   reg_done;
    logic   accept_q;
    logic   writeback_q;

    logic   issue_xfer;
    logic   reg_xfer;
    logic   result_xfer;
    logic   issue_done_n;
    logic   reg_done_n;
    logic   accept_n;
    logic   result_match;

    assign issue_xfer   = issue_valid_o & issue_ready_i;
    assign reg_xfer     = register_valid_o & register_ready_i;
    assign result_xfer  = result_valid_i & result_ready_o;
    assign issue_done_n = issue_done | issue_xfer;
    assign reg_done_n   = reg_done | reg_xfer;
    // The accept decision may arrive in the same cycle the register side finishes.
    assign accept_n     = issue_xfer ? issue_accept_i : accept_q;
    assign result_match = result_xfer && (result_id_i == commit_id_o);
    assign dbg_state_o  = state;

`ifdef CVXIF_REQ_TIMEOUT_EN
    logic [CntW-1:0] tmo_cnt;
    logic            tmo_hit;
    assign tmo_hit = (tmo_cnt == CntW'(TimeoutCycles - 1));
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            issue_done       <= 1'b0;
            reg_done         <= 1'b0;
            accept_q         <= 1'b0;
            writeback_q      <= 1'b0;
            cmd_ready_o      <= 1'b0;
            issue_valid_o    <= 1'b0;
            issue_instr_o    <= '0;
            issue_id_o       <= '0;
            register_valid_o <= 1'b0;
            register_rs1_o   <= '0;
            register_rs2_o   <= '0;
            register_id_o    <= '0;
            commit_valid_o   <= 1'b0;
            commit_id_o      <= '0;
            commit_kill_o    <= 1'b0;
            result_ready_o   <= 1'b0;
            rsp_valid_o      <= 1'b0;
            rsp_data_o       <= '0;
            rsp_rd_o         <= '0;
            rsp_we_o         <= 1'b0;
            rsp_status_o     <= STATUS_OK;
`ifdef CVXIF_REQ_TIMEOUT_EN
            tmo_cnt          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready_o <= 1'b1;
`ifdef CVXIF_REQ_TIMEOUT_EN
                    // Soak up results that arrive after their transaction timed out.
                    result_ready_o <= 1'b1;
`endif
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o      <= 1'b0;
                        result_ready_o   <= 1'b0;
                        issue_instr_o    <= cmd_instr_i;
                        issue_id_o       <= cmd_id_i;
                        register_id_o    <= cmd_id_i;
                        commit_id_o      <= cmd_id_i;
                        register_rs1_o   <= cmd_rs1_i;
                        register_rs2_o   <= cmd_rs2_i;
                        issue_valid_o    <= 1'b1;
                        register_valid_o <= 1'b1;
                        issue_done       <= 1'b0;
                        reg_done         <= 1'b0;
                        state            <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (issue_xfer) begin
                        issue_valid_o <= 1'b0;
                        issue_done    <= 1'b1;
                        accept_q      <= issue_accept_i;
                        writeback_q   <= issue_writeback_i;
                    end
                    if (reg_xfer) begin
                        register_valid_o <= 1'b0;
                        reg_done         <= 1'b1;
                    end
                    if (issue_done_n && reg_done_n) begin
                        commit_valid_o <= 1'b1;
                        commit_kill_o  <= ~accept_n;
                        state          <= S_COMMIT;
                    end
                end

                S_COMMIT: begin
                    commit_valid_o <= 1'b0;
                    commit_kill_o  <= 1'b0;
                    if (accept_q) begin
                        result_ready_o <= 1'b1;
                        state          <= S_WAIT_RES;
`ifdef CVXIF_REQ_TIMEOUT_EN
                        tmo_cnt        <= '0;
`endif
                    end else begin
                        rsp_valid_o  <= 1'b1;
                        rsp_status_o <= STATUS_REJECTED;
                        rsp_data_o   <= '0;
                        rsp_rd_o     <= '0;
                        rsp_we_o     <= 1'b0;
                        state        <= S_RSP;
                    end
                end

                S_WAIT_RES: begin
                    // Results carrying another id are consumed and dropped here.
                    if (result_match) begin
                        result_ready_o <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        rsp_status_o   <= STATUS_OK;
                        rsp_data_o     <= result_data_i;
                        rsp_rd_o       <= result_rd_i;
                        rsp_we_o       <= result_we_i & writeback_q;
                        state          <= S_RSP;
                    end
`ifdef CVXIF_REQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        result_ready_o <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        rsp_status_o   <= STATUS_TIMEOUT;
                        rsp_data_o     <= '0;
                        rsp_rd_o       <= '0;
                        rsp_we_o       <= 1'b0;
                        state          <= S_RSP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                S_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
`ifdef CVXIF_REQ_TIMEOUT_EN
                        result_ready_o <= 1'b1;
`endif
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cvxif_offload_requester.sv
// Bench for cvxif_offload_requester: reactive coprocessor model, response/commit scoreboards,
// directed cases followed by randomized transactions.
`timescale 1ns/1ps
module tb_cvxif_offload_requester;

    logic        clk;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_instr_i;
    logic [31:0] cmd_rs1_i;
    logic [31:0] cmd_rs2_i;
    logic [3:0]  cmd_id_i;
    logic        issue_valid_o;
    logic        issue_ready_i;
    logic [31:0] issue_instr_o;
    logic [3:0]  issue_id_o;
    logic        issue_accept_i;
    logic        issue_writeback_i;
    logic        register_valid_o;
    logic        register_ready_i;
    logic [31:0] register_rs1_o;
    logic [31:0] register_rs2_o;
    logic [3:0]  register_id_o;
    logic        commit_valid_o;
    logic [3:0]  commit_id_o;
    logic        commit_kill_o;
    logic        result_valid_i;
    logic        result_ready_o;
    logic [3:0]  result_id_i;
    logic [31:0] result_data_i;
    logic [4:0]  result_rd_i;
    logic        result_we_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_we_o;
    logic [1:0]  rsp_status_o;
    logic [2:0]  dbg_state;

    cvxif_offload_requester #(
        .XLEN(32),
        .IdWidth(4)
`ifdef CVXIF_REQ_TIMEOUT_EN
        ,
        .TimeoutCycles(16)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_instr_i(cmd_instr_i),
        .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i), .cmd_id_i(cmd_id_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_instr_o(issue_instr_o),
        .issue_id_o(issue_id_o), .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
        .register_valid_o(register_valid_o), .register_ready_i(register_ready_i),
        .register_rs1_o(register_rs1_o), .register_rs2_o(register_rs2_o), .register_id_o(register_id_o),
        .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
        .result_valid_i(result_valid_i), .result_ready_o(result_ready_o), .result_id_i(result_id_i),
        .result_data_i(result_data_i), .result_rd_i(result_rd_i), .result_we_i(result_we_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_rd_o(rsp_rd_o), .rsp_we_o(rsp_we_o), .rsp_status_o(rsp_status_o),
        .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [39:0] exp_q[$];          // {status, we, rd, data}
    logic [4:0]  exp_commit_q[$];   // {id, kill}

    // Per-transaction coprocessor behaviour, set by the driver before each command.
    int cfg_iss_dly = 0, cfg_reg_dly = 0, cfg_res_dly = 0, cfg_rsp_dly = 0;
    bit cfg_accept = 1, cfg_wb = 1, cfg_we = 1, cfg_wrong = 0, cfg_no_result = 0;
    logic [4:0]  cfg_rd = 5'd0;
    logic [31:0] cur_instr = '0, cur_rs1 = '0, cur_rs2 = '0;
    logic [3:0]  cur_id = '0;

    int cmd_cyc = 0, last_rsp_cyc = 0, last_commit_cyc = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- coprocessor model ----------------
    initial begin : coproc_issue
        int n = 0;
        issue_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (issue_valid_o) begin
                issue_ready_i = (n >= cfg_iss_dly);
                n++;
            end else begin
                issue_ready_i = 1'b0;
                n = 0;
            end
        end
    end

    initial begin : coproc_register
        int n = 0;
        register_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (register_valid_o) begin
                register_ready_i = (n >= cfg_reg_dly);
                n++;
            end else begin
                register_ready_i = 1'b0;
                n = 0;
            end
        end
    end

    initial begin : rsp_sink
        int n = 0;
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rsp_valid_o) begin
                rsp_ready_i = (n >= cfg_rsp_dly);
                n++;
            end else begin
                rsp_ready_i = 1'b0;
                n = 0;
            end
        end
    end

    task automatic send_result(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd,
                               input logic we);
        bit rdy;
        int g = 0;
        result_valid_i = 1'b1;
        result_id_i    = id;
        result_data_i  = d;
        result_rd_i    = rd;
        result_we_i    = we;
        rdy = result_ready_o;
        while (!rdy && g < 200) begin
            @(posedge clk); #1;
            rdy = result_ready_o;
            g++;
        end
        if (!rdy) begin
            errors++;
            $display("FAIL result_handshake actual=timeout expected=ready (cycle %0d)", cyc);
        end
        @(posedge clk); #1;
        result_valid_i = 1'b0;
    endtask

    initial begin : coproc_result
        logic [31:0] c_rs1, c_rs2;
        logic [3:0]  c_id;
        c_rs1 = '0; c_rs2 = '0; c_id = '0;
        result_valid_i = 1'b0; result_id_i = '0; result_data_i = '0;
        result_rd_i = '0; result_we_i = 1'b0;
        forever begin
            @(negedge clk);
            if (register_valid_o && register_ready_i) begin
                c_rs1 = register_rs1_o;
                c_rs2 = register_rs2_o;
            end
            if (issue_valid_o && issue_ready_i) c_id = issue_id_o;
            if (commit_valid_o && !commit_kill_o && !cfg_no_result && !rst_i) begin
                if (cfg_res_dly > 0) begin
                    repeat (cfg_res_dly) @(posedge clk);
                    #1;
                end
                if (cfg_wrong) send_result(c_id ^ 4'h1, ~(c_rs1 + c_rs2), 5'd31, 1'b1);
                send_result(c_id, c_rs1 + c_rs2, cfg_rd, cfg_we);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit in_flight = 0, iss_seen = 0, reg_seen = 0, acc_commit = 0;
        bit p_iss_v = 0, p_iss_r = 0, p_reg_v = 0, p_reg_r = 0, p_rsp_v = 0, p_rsp_r = 0, p_commit = 0;
        logic [35:0] p_iss;
        logic [67:0] p_reg;
        logic [39:0] p_rsp, got, exp;
        logic [4:0]  ec;
        p_iss = '0; p_reg = '0; p_rsp = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                in_flight = 0; p_iss_v = 0; p_reg_v = 0; p_rsp_v = 0; p_commit = 0;
                continue;
            end
            if (in_flight) chk("result_ready_before_accept", result_ready_o && !acc_commit, 1'b0);
            if (cmd_valid_i && cmd_ready_o) begin
                in_flight = 1; iss_seen = 0; reg_seen = 0; acc_commit = 0;
            end
            if (p_iss_v && !p_iss_r)
                chk("issue_hold", {issue_valid_o, issue_instr_o, issue_id_o}, {1'b1, p_iss});
            if (issue_valid_o) chk("issue_payload", {issue_instr_o, issue_id_o}, {cur_instr, cur_id});
            if (p_reg_v && !p_reg_r)
                chk("register_hold", {register_valid_o, register_rs1_o, register_rs2_o, register_id_o},
                    {1'b1, p_reg});
            if (register_valid_o)
                chk("register_payload", {register_rs1_o, register_rs2_o, register_id_o},
                    {cur_rs1, cur_rs2, cur_id});
            if (issue_valid_o && issue_ready_i) iss_seen = 1;
            if (register_valid_o && register_ready_i) reg_seen = 1;
            if (commit_valid_o) begin
                chk("commit_single_cycle", p_commit, 1'b0);
                chk("commit_after_both", {iss_seen, reg_seen}, 2'b11);
                if (exp_commit_q.size() == 0) begin
                    chk("commit_unexpected", {commit_id_o, commit_kill_o}, 5'h1f ^ {commit_id_o, commit_kill_o});
                end else begin
                    ec = exp_commit_q.pop_front();
                    chk("commit_id_kill", {commit_id_o, commit_kill_o}, ec);
                end
                if (!commit_kill_o) acc_commit = 1;
                last_commit_cyc = cyc;
            end
            p_commit = commit_valid_o;
            if (rsp_valid_o) begin
                got = {rsp_status_o, rsp_we_o, rsp_rd_o, rsp_data_o};
                chk("cmd_ready_during_rsp", cmd_ready_o, 1'b0);
                if (p_rsp_v && !p_rsp_r) chk("rsp_hold", got, p_rsp);
                if (!p_rsp_v) last_rsp_cyc = cyc;
                if (rsp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", got, ~got);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("rsp_fields", got, exp);
                    end
                    in_flight = 0;
                end
            end
            p_iss_v = issue_valid_o; p_iss_r = issue_ready_i; p_iss = {issue_instr_o, issue_id_o};
            p_reg_v = register_valid_o; p_reg_r = register_ready_i;
            p_reg = {register_rs1_o, register_rs2_o, register_id_o};
            p_rsp_v = rsp_valid_o; p_rsp_r = rsp_ready_i;
            p_rsp = {rsp_status_o, rsp_we_o, rsp_rd_o, rsp_data_o};
        end
    end

    // ---------------- driver ----------------
    task automatic run_txn(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [3:0] id, input bit expect_rsp);
        logic [1:0]  st;
        logic [31:0] d;
        logic [4:0]  rd;
        logic        we;
        bit          got = 0;
        int          n = 0;
        if (!cfg_accept) begin
            st = 2'd1; d = '0; rd = '0; we = 1'b0;
        end else if (cfg_no_result) begin
            st = 2'd2; d = '0; rd = '0; we = 1'b0;
        end else begin
            st = 2'd0; d = rs1 + rs2; rd = cfg_rd; we = cfg_we & cfg_wb;
        end
        exp_commit_q.push_back({id, ~cfg_accept});
        if (expect_rsp) exp_q.push_back({st, we, rd, d});
        cur_instr = instr; cur_rs1 = rs1; cur_rs2 = rs2; cur_id = id;
        issue_accept_i = cfg_accept;
        issue_writeback_i = cfg_wb;
        cmd_instr_i = instr; cmd_rs1_i = rs1; cmd_rs2_i = rs2; cmd_id_i = id;
        cmd_valid_i = 1'b1;
        while (!got && n < 100) begin
            @(negedge clk);
            got = cmd_ready_o;
            if (got) cmd_cyc = cyc;
            @(posedge clk); #1;
            n++;
        end
        cmd_valid_i = 1'b0;
        chk("cmd_accepted", got, 1'b1);
        if (expect_rsp) begin
            n = 0;
            while (exp_q.size() != 0 && n < 300) begin
                @(posedge clk);
                n++;
            end
            #1;
            chk("rsp_arrived", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic set_cfg(input int iss, input int rg, input int res, input int rsp, input bit acc,
                           input bit wb, input bit we, input logic [4:0] rd, input bit wrong, input bit nores);
        cfg_iss_dly = iss; cfg_reg_dly = rg; cfg_res_dly = res; cfg_rsp_dly = rsp;
        cfg_accept = acc; cfg_wb = wb; cfg_we = we; cfg_rd = rd; cfg_wrong = wrong; cfg_no_result = nores;
    endtask

    initial begin : main
        int n;
        cmd_valid_i = 1'b0; cmd_instr_i = '0; cmd_rs1_i = '0; cmd_rs2_i = '0; cmd_id_i = '0;
        issue_accept_i = 1'b0; issue_writeback_i = 1'b0;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valids", {cmd_ready_o, issue_valid_o, register_valid_o, commit_valid_o,
                             result_ready_o, rsp_valid_o, commit_kill_o}, 7'b0);
        chk("reset_data", {issue_instr_o, register_rs1_o, rsp_data_o, rsp_rd_o, rsp_status_o}, 103'b0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("reset_release_ready_low", cmd_ready_o, 1'b0);
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready_o, 1'b1);
        @(posedge clk); #1;

        // Accepting coprocessor, minimum latency
        set_cfg(0, 0, 0, 0, 1, 1, 1, 5'd10, 0, 0);
        run_txn(32'h0000_000B, 32'd5, 32'd7, 4'd3, 1);
        chk("min_latency_rsp", last_rsp_cyc - cmd_cyc, 4);
        chk("min_latency_commit", last_commit_cyc - cmd_cyc, 2);

        // Rejected instruction
        set_cfg(0, 0, 0, 0, 0, 1, 1, 5'd10, 0, 0);
        run_txn(32'h0000_002B, 32'd9, 32'd1, 4'd6, 1);

        // Issue stalled 3 cycles, register stalled 5 cycles
        set_cfg(3, 5, 0, 0, 1, 1, 1, 5'd4, 0, 0);
        run_txn(32'h1234_500B, 32'd100, 32'd23, 4'd9, 1);
        chk("commit_after_stalls", last_commit_cyc - cmd_cyc, 7);

        // Mismatching result id dropped first
        set_cfg(0, 0, 1, 0, 1, 1, 1, 5'd12, 1, 0);
        run_txn(32'h0000_000B, 32'd40, 32'd2, 4'd3, 1);

        // Response back-pressure, writeback not requested
        set_cfg(1, 0, 2, 4, 1, 0, 1, 5'd7, 0, 0);
        run_txn(32'h0000_005B, 32'hFFFF_FFFF, 32'd2, 4'd14, 1);

`ifdef CVXIF_REQ_TIMEOUT_EN
        set_cfg(0, 0, 0, 0, 1, 1, 1, 5'd3, 0, 1);
        run_txn(32'h0000_007B, 32'd1, 32'd2, 4'd5, 1);
        chk("timeout_latency", last_rsp_cyc - last_commit_cyc, 17);
        @(negedge clk);
        chk("idle_drains_results", {cmd_ready_o, result_ready_o}, 2'b11);
        @(posedge clk); #1;
`endif

        // Reset while waiting for a result
        set_cfg(0, 0, 0, 0, 1, 1, 1, 5'd3, 0, 1);
        run_txn(32'h0000_00AB, 32'd8, 32'd8, 4'd11, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!result_ready_o && n < 20);
        chk("reached_wait_res", result_ready_o, 1'b1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {cmd_ready_o, issue_valid_o, register_valid_o, commit_valid_o,
                                 result_ready_o, rsp_valid_o}, 6'b0);
        @(negedge clk);
        chk("midreset_cmd_ready", {cmd_ready_o, commit_valid_o, rsp_valid_o}, 3'b100);
        chk("midreset_no_commit", exp_commit_q.size(), 0);
        @(posedge clk); #1;

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            set_cfg($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 4),
                    ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                    5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0), 0);
            run_txn($urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 1);
        end
        chk("commit_queue_drained", exp_commit_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        repeat (50000) @(posedge clk);
        errors++;
        $display("FAIL watchdog actual=running expected=finished (dut state %0d)", dbg_state);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
